// File: rtl/prog_loader.sv
// Boot loader: parses A5/LEN/words/CSUM frames into I-ROM writes.
// Ports: i_byte/i_valid/o_ready stream in; o_we/o_waddr/o_wdata out; o_cpu_run/o_err status.
module prog_loader #(
  parameter logic [31:0] BASE      = 32'd0,
  parameter logic [15:0] MAX_WORDS = 16'd256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_we,
  output logic [31:0] o_waddr,
  output logic [15:0] o_wdata,
  output logic        o_cpu_run,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] MAGIC = 8'hA5;

  state_t      state_q;
  logic        rdy_q;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [31:0] addr_q;
  logic [7:0]  lo_q;
  logic [7:0]  csum_q;
  logic        we_q;
  logic [31:0] waddr_q;
  logic [15:0] wdata_q;
  logic        run_q;
  logic        err_q;

  logic        xfer;
  logic [15:0] len_d;
  logic [15:0] cnt_d;
  logic [7:0]  csum_d;

  assign xfer   = i_valid && rdy_q;
  assign len_d  = {i_byte, len_lo_q};
  assign cnt_d  = cnt_q + 16'd1;
  assign csum_d = csum_q ^ i_byte;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      len_lo_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      lo_q     <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      // write strobe is a single-cycle pulse
      we_q  <= 1'b0;
      if (xfer) begin
        unique case (state_q)
          S_IDLE, S_DONE, S_ERR: begin
            if (i_byte == MAGIC) begin
              state_q <= S_LEN_LO;
              csum_q  <= '0;
              run_q   <= 1'b0;
              err_q   <= 1'b0;
            end
          end
          S_LEN_LO: begin
            len_lo_q <= i_byte;
            csum_q   <= csum_d;
            state_q  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len_q  <= len_d;
            csum_q <= csum_d;
            cnt_q  <= '0;
            addr_q <= BASE;
            if (len_d > MAX_WORDS) begin
              // oversize frame: rejected, processor stays held
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            lo_q    <= i_byte;
            csum_q  <= csum_d;
            state_q <= S_DATA_HI;
          end
          S_DATA_HI: begin
            we_q    <= 1'b1;
            waddr_q <= addr_q;
            wdata_q <= {i_byte, lo_q};
            addr_q  <= addr_q + 32'd2;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            state_q <= (cnt_d == len_q) ? S_CSUM : S_DATA_LO;
          end
          S_CSUM: begin
            if (i_byte == csum_q) begin
              state_q <= S_DONE;
              run_q   <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ready   = rdy_q;
  assign o_we      = we_q;
  assign o_waddr   = waddr_q;
  assign o_wdata   = wdata_q;
  assign o_cpu_run = run_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames, checksum, oversize, gaps, reset abort.
// Writes are logged at the falling edge and compared with hand-derived values.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_i;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] waddr;
  logic [15:0] wdata;
  logic        run;
  logic        err;

  int n_chk;
  int n_fail;

  logic [47:0] wq[$];

  prog_loader #(
    .BASE     (32'd0),
    .MAX_WORDS(16'd256)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_byte   (byte_i),
    .i_valid  (valid),
    .o_ready  (ready),
    .o_we     (we),
    .o_waddr  (waddr),
    .o_wdata  (wdata),
    .o_cpu_run(run),
    .o_err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (we) wq.push_back({waddr, wdata});

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb(input logic [7:0] b, input int gap = 0);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_i = b;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    valid  = 1'b0;
  endtask

  task automatic good_frame(input int gmax);
    sb(8'hA5, $urandom_range(gmax));
    sb(8'h02, $urandom_range(gmax));
    sb(8'h00, $urandom_range(gmax));
    sb(8'h34, $urandom_range(gmax));
    sb(8'h12, $urandom_range(gmax));
    sb(8'h78, $urandom_range(gmax));
    sb(8'h56, $urandom_range(gmax));
    sb(8'h0A, $urandom_range(gmax));
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    valid  = 1'b0;
    byte_i = 8'h00;
    #12;
    chk("rst_ready", ready, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_run", run, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_up", ready, 1);

    // good frame, back-to-back, with cycle-exact write checks
    sb(8'hA5);
    sb(8'h02);
    sb(8'h00);
    sb(8'h34);
    sb(8'h12);
    chk("a_we0", we, 1);
    chk("a_addr0", waddr, 32'h0);
    chk("a_data0", wdata, 16'h1234);
    sb(8'h78);
    chk("a_we_pulse", we, 0);
    sb(8'h56);
    chk("a_we1", we, 1);
    chk("a_addr1", waddr, 32'h2);
    chk("a_data1", wdata, 16'h5678);
    chk("a_run_pre", run, 0);
    sb(8'h0A);
    chk("a_we_end", we, 0);
    chk("a_run", run, 1);
    chk("a_err", err, 0);
    @(negedge clk);
    chk("a_nwrites", wq.size(), 2);

    // bad checksum: writes land, processor held
    wq.delete();
    sb(8'hA5);
    chk("b_run_drop", run, 0);
    sb(8'h02);
    sb(8'h00);
    sb(8'h34);
    sb(8'h12);
    sb(8'h78);
    sb(8'h56);
    sb(8'h0B);
    @(negedge clk);
    chk("b_nwrites", wq.size(), 2);
    chk("b_w0", wq[0], {32'h0, 16'h1234});
    chk("b_w1", wq[1], {32'h2, 16'h5678});
    chk("b_run", run, 0);
    chk("b_err", err, 1);

    // zero-length frame
    wq.delete();
    sb(8'hA5);
    chk("z_err_drop", err, 0);
    sb(8'h00);
    sb(8'h00);
    sb(8'h00);
    @(negedge clk);
    chk("z_nwrites", wq.size(), 0);
    chk("z_run", run, 1);
    chk("z_err", err, 0);

    // oversize length 257; trailing bytes ignored
    wq.delete();
    sb(8'hA5);
    sb(8'h01);
    sb(8'h01);
    sb(8'h34);
    sb(8'h12);
    sb(8'h00);
    sb(8'h00);
    sb(8'h00);
    @(negedge clk);
    chk("o_nwrites", wq.size(), 0);
    chk("o_run", run, 0);

    // garbage then good frame with random gaps
    wq.delete();
    sb(8'h00);
    sb(8'hFF);
    sb(8'h5A);
    chk("g_run_idle", run, 0);
    good_frame(3);
    chk("g_nwrites", wq.size(), 2);
    chk("g_w0", wq[0], {32'h0, 16'h1234});
    chk("g_w1", wq[1], {32'h2, 16'h5678});
    chk("g_run", run, 1);
    chk("g_err", err, 0);
    sb(8'hA5);
    chk("g_restart", run, 0);

    // reset during the first write of a 3-word frame
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wq.delete();
    sb(8'hA5);
    sb(8'h03);
    sb(8'h00);
    sb(8'h11);
    sb(8'h11);
    chk("r_we1", we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_we", we, 0);
    chk("r_waddr", waddr, 0);
    chk("r_wdata", wdata, 0);
    chk("r_ready", ready, 0);
    chk("r_run", run, 0);
    byte_i = 8'h22;
    valid  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb(8'h33);
    sb(8'h44);
    @(negedge clk);
    chk("r_nowrite", wq.size(), 0);
    good_frame(0);
    chk("r2_nwrites", wq.size(), 2);
    chk("r2_w0", wq[0], {32'h0, 16'h1234});
    chk("r2_w1", wq[1], {32'h2, 16'h5678});
    chk("r2_run", run, 1);
    chk("r2_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
